// File: rtl/grad_read_arbiter_if.sv
// rtl/grad_read_arbiter_if.sv - requester, response and BRAM signal bundle for grad_read_arbiter
interface grad_read_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int BIT_DEPTH  = 8
);
  logic                     req0_valid;
  logic [ADDR_WIDTH-1:0]    req0_addr;
  logic                     req0_lock;
  logic                     req0_ready;
  logic                     rsp0_valid;
  logic [2*BIT_DEPTH-1:0]   rsp0_data;

  logic                     req1_valid;
  logic [ADDR_WIDTH-1:0]    req1_addr;
  logic                     req1_lock;
  logic                     req1_ready;
  logic                     rsp1_valid;
  logic [2*BIT_DEPTH-1:0]   rsp1_data;

  logic [ADDR_WIDTH-1:0]    bram_addr;
  logic                     bram_en;
  logic [2*BIT_DEPTH-1:0]   bram_data;
  logic [15:0]              conflict_count;

  modport master (
    output req0_valid, req0_addr, req0_lock,
    output req1_valid, req1_addr, req1_lock,
    output bram_data,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  bram_addr, bram_en, conflict_count
  );

  modport slave (
    input  req0_valid, req0_addr, req0_lock,
    input  req1_valid, req1_addr, req1_lock,
    input  bram_data,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output bram_addr, bram_en, conflict_count
  );
endinterface

// File: rtl/grad_read_arbiter.sv
// rtl/grad_read_arbiter.sv - round-robin/lockable arbiter sharing one gradient BRAM read port
module grad_read_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int BIT_DEPTH    = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_in,
  grad_read_arbiter_if.slave bus
);

  typedef enum logic [1:0] {LOCK_NONE, LOCK_REQ0, LOCK_REQ1} lock_e;
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  lock_e                       lock_q, lock_d;
  logic                        ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [15:0]                 conf_q, conf_d;
  tag_t [READ_LATENCY-1:0]     tag_q, tag_d;

  logic                        both;
  logic                        accept;
  logic                        winner;
  logic                        win_lock;
  logic [ADDR_WIDTH-1:0]       win_addr;
  tag_t                        tail;

  assign both = bus.req0_valid & bus.req1_valid;

  // Grants are suppressed during reset so every output reads 0 immediately.
  always_comb begin
    accept = 1'b0;
    winner = 1'b0;
    if (!rst_in) begin
      if (both) begin
        accept = 1'b1;
        case (lock_q)
          LOCK_REQ0: winner = 1'b0;
          LOCK_REQ1: winner = 1'b1;
          default:   winner = ptr_q;
        endcase
      end else if (bus.req0_valid) begin
        accept = 1'b1;
        winner = 1'b0;
      end else if (bus.req1_valid) begin
        accept = 1'b1;
        winner = 1'b1;
      end
    end
    win_addr = winner ? bus.req1_addr : bus.req0_addr;
    win_lock = winner ? bus.req1_lock : bus.req0_lock;
  end

  always_comb begin
    ptr_d  = ptr_q;
    lock_d = lock_q;
    addr_d = addr_q;
    conf_d = conf_q;
    tag_d  = tag_q;
    if (accept) begin
      ptr_d  = ~winner;
      addr_d = win_addr;
    end
    if ((lock_q == LOCK_REQ0 && !bus.req0_lock) ||
        (lock_q == LOCK_REQ1 && !bus.req1_lock)) begin
      lock_d = LOCK_NONE;
    end
    // A fresh locked acceptance takes ownership even if the old owner still holds lock.
    if (accept && win_lock) begin
      lock_d = winner ? LOCK_REQ1 : LOCK_REQ0;
    end
    if (both && conf_q != 16'hFFFF) begin
      conf_d = conf_q + 16'd1;
    end
    tag_d[0].valid = accept;
    tag_d[0].id    = winner;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      ptr_q  <= 1'b0;
      lock_q <= LOCK_NONE;
      addr_q <= '0;
      conf_q <= '0;
      tag_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      lock_q <= lock_d;
      addr_q <= addr_d;
      conf_q <= conf_d;
      tag_q  <= tag_d;
    end
  end

  assign tail = tag_q[READ_LATENCY-1];

  assign bus.req0_ready     = accept & ~winner;
  assign bus.req1_ready     = accept & winner;
  assign bus.bram_en        = accept;
  assign bus.bram_addr      = accept ? win_addr : addr_q;
  assign bus.rsp0_valid     = tail.valid & ~tail.id;
  assign bus.rsp1_valid     = tail.valid & tail.id;
  assign bus.rsp0_data      = rst_in ? '0 : bus.bram_data;
  assign bus.rsp1_data      = rst_in ? '0 : bus.bram_data;
  assign bus.conflict_count = conf_q;

endmodule

// File: tb/tb_grad_read_arbiter.sv
// tb/tb_grad_read_arbiter.sv - randomized and directed self-checking bench for grad_read_arbiter
module tb_grad_read_arbiter;
  localparam int AW  = 12;
  localparam int BD  = 8;
  localparam int LAT = 2;
  localparam int DW  = 2*BD;

  logic clk = 1'b0;
  logic rst_in;
  always #5 clk = ~clk;

  grad_read_arbiter_if #(.ADDR_WIDTH(AW), .BIT_DEPTH(BD)) bus ();

  grad_read_arbiter #(.ADDR_WIDTH(AW), .BIT_DEPTH(BD), .READ_LATENCY(LAT)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [DW-1:0] mem [0:4095];

  // Reference state: who is favoured, who owns the lock, last issued address,
  // conflict tally, and a calendar of responses keyed by the cycle they are due.
  bit            m_ptr;
  bit            m_lock_on;
  bit            m_lock_id;
  logic [AW-1:0] m_shadow;
  int            m_conf;
  bit            due_v  [8];
  bit            due_id [8];
  logic [AW-1:0] due_a  [8];
  bit            hist_en[8];
  logic [AW-1:0] hist_a [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int s;
    int d;
    bit v0, v1, acc, w, rv, rid;
    logic [AW-1:0] ea;
    s = cyc % 8;
    if (rst_in) begin
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_en", bus.bram_en, 0);
      chk("rst_addr", bus.bram_addr, 0);
      chk("rst_rsp0v", bus.rsp0_valid, 0);
      chk("rst_rsp1v", bus.rsp1_valid, 0);
      chk("rst_rsp0d", bus.rsp0_data, 0);
      chk("rst_rsp1d", bus.rsp1_data, 0);
      chk("rst_conf", bus.conflict_count, 0);
      m_ptr = 0; m_lock_on = 0; m_lock_id = 0; m_shadow = '0; m_conf = 0;
      for (int i = 0; i < 8; i++) due_v[i] = 0;
    end else begin
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      acc = v0 | v1;
      if (v0 && v1) w = m_lock_on ? m_lock_id : m_ptr;
      else          w = v1;
      ea = !acc ? m_shadow : (w ? bus.req1_addr : bus.req0_addr);
      chk("ready0", bus.req0_ready, acc && !w);
      chk("ready1", bus.req1_ready, acc && w);
      chk("bram_en", bus.bram_en, acc);
      chk("bram_addr", bus.bram_addr, ea);
      rv = due_v[s];
      rid = due_id[s];
      chk("rsp0_valid", bus.rsp0_valid, rv && !rid);
      chk("rsp1_valid", bus.rsp1_valid, rv && rid);
      if (rv && !rid) chk("rsp0_data", bus.rsp0_data, mem[due_a[s]]);
      if (rv && rid)  chk("rsp1_data", bus.rsp1_data, mem[due_a[s]]);
      chk("conflict", bus.conflict_count, m_conf);
      due_v[s] = 0;
      if (acc) begin
        d = (cyc + LAT) % 8;
        due_v[d] = 1; due_id[d] = w; due_a[d] = ea;
        m_ptr = !w;
        m_shadow = ea;
      end
      if (v0 && v1 && m_conf < 65535) m_conf++;
      if (m_lock_on && !(m_lock_id ? bus.req1_lock : bus.req0_lock)) m_lock_on = 0;
      if (acc && (w ? bus.req1_lock : bus.req0_lock)) begin
        m_lock_on = 1; m_lock_id = w;
      end
    end
    hist_en[s] = bus.bram_en;
    hist_a[s]  = bus.bram_addr;
    cyc++;
  end

  task automatic drive(input bit v0, input int a0, input bit l0, input bit v1, input int a1, input bit l1);
    int h;
    @(posedge clk);
    #1;
    bus.req0_valid = v0; bus.req0_addr = AW'(a0); bus.req0_lock = l0;
    bus.req1_valid = v1; bus.req1_addr = AW'(a1); bus.req1_lock = l1;
    h = (cyc + 8 - LAT) % 8;
    if (cyc >= LAT && hist_en[h]) bus.bram_data = mem[hist_a[h]];
    else                          bus.bram_data = DW'($urandom);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_in = 1'b1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_lock = 0;  bus.req1_lock = 0;
    @(posedge clk);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
    mem[5] = 16'h7F80;
    rst_in = 1'b1;
    bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_lock = 0;
    bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_lock = 0;
    bus.bram_data = '0;
    at_neg();
    chk("init_conf", bus.conflict_count, 0);
    chk("init_rsp0", bus.rsp0_valid, 0);
    #10;
    rst_in = 1'b0;

    // contention from reset: strict alternation starting with requester 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, $urandom_range(0, 4095), 0, 1, $urandom_range(0, 4095), 0);
      at_neg();
      chk("rr_ready0", bus.req0_ready, (i % 2) == 0);
      chk("rr_ready1", bus.req1_ready, (i % 2) == 1);
    end
    idle(); at_neg();
    chk("rr_conflict", bus.conflict_count, 6);
    idle(); idle();

    // single read: pinned address and data
    do_reset();
    drive(1, 5, 0, 0, 0, 0); at_neg();
    chk("single_ready0", bus.req0_ready, 1);
    chk("single_addr", bus.bram_addr, 12'h005);
    idle(); at_neg();
    chk("single_early", bus.rsp0_valid, 0);
    idle(); at_neg();
    chk("single_rsp0v", bus.rsp0_valid, 1);
    chk("single_rsp0d", bus.rsp0_data, 16'h7F80);
    chk("single_rsp1v", bus.rsp1_valid, 0);
    idle(); at_neg();
    chk("single_addr_hold", bus.bram_addr, 12'h005);

    // locked patch burst: lock drops on the 16th beat
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, $urandom_range(0, 4095), i < 15, 1, $urandom_range(0, 4095), 0);
      at_neg();
      chk("lock_ready0", bus.req0_ready, 1);
    end
    drive(1, 1, 0, 1, 2, 0); at_neg();
    chk("lock_release_ready1", bus.req1_ready, 1);
    idle(); idle(); idle();

    // back-to-back streaming from requester 1
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive(0, 0, 0, 1, i, 0);
      else        idle();
      at_neg();
      chk("stream_rsp1v", bus.rsp1_valid, i >= 2);
      if (i >= 2) chk("stream_rsp1d", bus.rsp1_data, mem[i-2]);
    end

    // asynchronous reset while two reads are in flight
    do_reset();
    drive(1, 12'h100, 0, 0, 0, 0); at_neg();
    chk("mid_ready0", bus.req0_ready, 1);
    drive(0, 0, 0, 1, 12'h200, 0); at_neg();
    chk("mid_ready1", bus.req1_ready, 1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("mid_now_ready1", bus.req1_ready, 0);
    chk("mid_now_en", bus.bram_en, 0);
    chk("mid_now_addr", bus.bram_addr, 0);
    for (int i = 0; i < 2; i++) begin
      idle(); at_neg();
      chk("mid_rsp0v", bus.rsp0_valid, 0);
      chk("mid_rsp1v", bus.rsp1_valid, 0);
    end
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0); at_neg();
      chk("post_rsp0v", bus.rsp0_valid, 0);
      chk("post_rsp1v", bus.rsp1_valid, 0);
    end
    drive(1, 7, 0, 1, 8, 0); at_neg();
    chk("post_ptr_ready0", bus.req0_ready, 1);
    idle(); idle(); idle();

    // randomized traffic against the reference model
    do_reset();
    repeat (3000) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 4095), $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 6, $urandom_range(0, 4095), $urandom_range(0, 3) == 0);
    end
    idle(); idle(); idle();

    // conflict counter saturation
    do_reset();
    repeat (70000) drive(1, $urandom_range(0, 4095), 0, 1, $urandom_range(0, 4095), 0);
    at_neg();
    chk("sat_conf", bus.conflict_count, 16'hFFFF);
    repeat (5) drive(1, 3, 0, 1, 4, 0);
    at_neg();
    chk("sat_hold", bus.conflict_count, 16'hFFFF);
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/grad_read_arbiter.md
Name: grad_read_arbiter

Overview:
Shares one gradient-pyramid BRAM read port (x and y gradient packed into one word) between two requesters. Requester 0 is the descriptor histogram reader; requester 1 is the orientation/debug reader. Arbitration is round-robin with an optional lock for patch bursts. A tag pipeline returns each read word to its issuer exactly READ_LATENCY cycles after acceptance. One instance sits in front of each octave/level gradient BRAM pair.

Parameters:
ADDR_WIDTH, 12, BRAM address width (DIMENSION*DIMENSION = 4096 for octave 1).
BIT_DEPTH, 8, width of one signed gradient component.
READ_LATENCY, 2, BRAM cycles from address to data; legal range 1..4.

Ports:
clk  in  1  system clock.
rst_in  in  1  reset; asynchronous, active-high.
req0_valid  in  1  requester 0 has a read pending.
req0_addr  in  ADDR_WIDTH  requester 0 read address.
req0_lock  in  1  requester 0 asks to keep the grant while it holds the port.
req0_ready  out  1  requester 0 read accepted this cycle.
rsp0_valid  out  1  requester 0 read data valid.
rsp0_data  out  2*BIT_DEPTH  {x_grad, y_grad} for requester 0.
req1_valid, req1_addr, req1_lock, req1_ready, rsp1_valid, rsp1_data  (same directions, widths and meanings as requester 0, for requester 1).
bram_addr  out  ADDR_WIDTH  shared BRAM read address.
bram_en  out  1  BRAM read enable.
bram_data  in  2*BIT_DEPTH  BRAM read word {x_grad, y_grad}.
conflict_count  out  16  saturating count of cycles in which both requesters were valid.

Behaviour:
- Reset values: all outputs 0. The round-robin pointer favours requester 0. The tag pipeline is empty, the lock owner is none, and conflict_count is 0.
- Reset is asynchronous. Reset mid-operation flushes all in-flight tags. No rsp*_valid pulse may occur for reads accepted before reset.
- Arbitration is combinational within a cycle:
  - Only one requester valid: that requester wins.
  - Both valid and lock owner set: the lock owner wins.
  - Both valid, no lock owner: the requester favoured by the pointer wins.
- reqN_ready = winner==N. At most one ready per cycle. A request is accepted on valid&ready.
- bram_en = any request accepted. bram_addr = the winner's address. When idle, bram_addr holds its last value (registered shadow) to avoid BRAM address toggling.
- Pointer update: on acceptance by N, the pointer favours the other requester next cycle.
- Lock:
  - On acceptance by N with reqN_lock=1, the lock owner becomes N.
  - The lock owner clears in the first cycle the owner has lock=0, whether or not the owner is valid.
  - While locked, the non-owner may still win in cycles where the owner is not valid.
- Tag pipeline: a shift register of READ_LATENCY entries, each {valid, id}. The entry for an acceptance at edge t reaches the output during cycle t+READ_LATENCY.
- rspN_valid = tail.valid && tail.id==N. Both rspN_data outputs are driven combinationally from bram_data. Data is only meaningful while the matching valid is high.
- Throughput: one acceptance per cycle sustained, no bubbles. There is no backpressure on responses; requesters must always accept.
- conflict_count increments on each cycle with req0_valid&req1_valid and saturates at 16'hFFFF.
- Address is passed through unmodified. No range checking; address wrap is the requester's responsibility.

Test Plan:
- Single requester: req0 valid with addr 0x005 at cycle 0 → req0_ready=1 and bram_addr=0x005 in cycle 0. With bram_data=16'h7F80 presented, rsp0_valid=1 and rsp0_data=16'h7F80 in cycle 2. rsp1_valid stays 0.
- Contention round-robin: both valid continuously for 6 cycles → grants 0,1,0,1,0,1. Responses alternate two cycles later. conflict_count=6.
- Lock burst: req0 lock=1 for 16 back-to-back reads (patch) with req1 also valid → 16 consecutive grants to 0. Req1 is granted in the cycle after req0_lock drops.
- Back-to-back streaming: req1 alone issues addrs 0..9 on consecutive cycles → 10 consecutive rsp1_valid cycles starting at cycle 2. Data order matches address order.
- Reset mid-flight: accept two reads, assert rst_in asynchronously before their responses → no rsp*_valid. All outputs are 0 immediately; the pointer favours requester 0 after reset.
- Saturation: force 70000 conflict cycles → conflict_count=16'hFFFF and holds.
